// File: rtl/star_scan_sequencer_pkg.sv
// Shared definitions for the star-finding pipeline: default geometry, FSM states
// and the raster address formula used by both the scanner and the extent finder.
package star_scan_sequencer_pkg;

    localparam int DEF_X_SZ      = 3;
    localparam int DEF_Y_SZ      = 3;
    localparam int DEF_ADDR_SZ   = 6;
    localparam int DEF_COL_SZ    = 3;
    localparam int DEF_WIDTH     = 6;
    localparam int DEF_HEIGHT    = 6;
    localparam int DEF_THRESHOLD = 0;
    localparam int DEF_MAX_STARS = 4;

    // Field widths of one bounding-box record (top/bottom are rows, left/right columns)
    localparam int BOX_ROW_SZ = DEF_Y_SZ;
    localparam int BOX_COL_SZ = DEF_X_SZ;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN_ADDR = 3'd1,
        ST_SCAN_CHK  = 3'd2,
        ST_LAUNCH    = 3'd3,
        ST_WAIT_FIND = 3'd4,
        ST_EMIT      = 3'd5,
        ST_DONE      = 3'd6
    } scanState_t;

    // Operands are passed zero-extended so the product never wraps before truncation
    function automatic logic [31:0] pixAddr(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] width);
        return y * width + x;
    endfunction

endpackage

// File: rtl/star_scan_sequencer_table.sv
// Exclusion table of recorded star boxes; answers whether a pixel is already covered.
module star_box_table #(
    parameter int X_SZ      = 3,
    parameter int Y_SZ      = 3,
    parameter int MAX_STARS = 4,
    parameter int IDX_SZ    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              wrEn,
    input  logic [IDX_SZ-1:0] wrIdx,
    input  logic [Y_SZ-1:0]   wrTop,
    input  logic [Y_SZ-1:0]   wrBottom,
    input  logic [X_SZ-1:0]   wrLeft,
    input  logic [X_SZ-1:0]   wrRight,
    input  logic [X_SZ-1:0]   qX,
    input  logic [Y_SZ-1:0]   qY,
    output logic              covered
);

    logic [MAX_STARS-1:0] entryValid;
    logic [Y_SZ-1:0]      boxTop    [MAX_STARS];
    logic [Y_SZ-1:0]      boxBottom [MAX_STARS];
    logic [X_SZ-1:0]      boxLeft   [MAX_STARS];
    logic [X_SZ-1:0]      boxRight  [MAX_STARS];

    // Box contents need no reset; only the valid bits gate the query
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            entryValid <= '0;
        end else if (wrEn) begin
            entryValid[wrIdx] <= 1'b1;
            boxTop[wrIdx]     <= wrTop;
            boxBottom[wrIdx]  <= wrBottom;
            boxLeft[wrIdx]    <= wrLeft;
            boxRight[wrIdx]   <= wrRight;
        end
    end

    always_comb begin
        covered = 1'b0;
        for (int i = 0; i < MAX_STARS; i++) begin
            if (entryValid[i] &&
                qX >= boxLeft[i] && qX <= boxRight[i] &&
                qY >= boxTop[i]  && qY <= boxBottom[i])
                covered = 1'b1;
        end
    end

endmodule

// File: rtl/star_scan_sequencer.sv
// Frame controller: raster-scans pixel RAM, launches the extent finder on uncovered
// bright pixels, shares the RAM read port with it and emits one box per star.
module star_scan_sequencer
    import star_scan_sequencer_pkg::*;
#(
    parameter int X_SZ      = DEF_X_SZ,
    parameter int Y_SZ      = DEF_Y_SZ,
    parameter int ADDR_SZ   = DEF_ADDR_SZ,
    parameter int COL_SZ    = DEF_COL_SZ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int THRESHOLD = DEF_THRESHOLD,
    parameter int MAX_STARS = DEF_MAX_STARS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [ADDR_SZ-1:0] ram_addr,
    input  logic [COL_SZ-1:0]  pix_q,
    output logic               find_start,
    output logic [X_SZ-1:0]    find_x,
    output logic [Y_SZ-1:0]    find_y,
    input  logic [ADDR_SZ-1:0] find_addr,
    input  logic               find_done,
    input  logic [Y_SZ-1:0]    find_top,
    input  logic [Y_SZ-1:0]    find_bottom,
    input  logic [X_SZ-1:0]    find_left,
    input  logic [X_SZ-1:0]    find_right,
    output logic               star_valid,
    input  logic               star_ready,
    output logic [Y_SZ-1:0]    star_top,
    output logic [Y_SZ-1:0]    star_bottom,
    output logic [X_SZ-1:0]    star_left,
    output logic [X_SZ-1:0]    star_right,
    output logic [2:0]         star_count,
    output logic               busy,
    output logic               frame_done,
    output logic               overflow
);

    localparam int IDX_SZ = (MAX_STARS > 1) ? $clog2(MAX_STARS) : 1;

    scanState_t       state;
    logic [X_SZ-1:0]  x;
    logic [Y_SZ-1:0]  y;
    logic [ADDR_SZ-1:0] scanAddr;
    logic             bright;
    logic             covered;
    logic             lastPixel;
    logic             lastColumn;
    logic             tableClear;
    logic             tableWrite;

    assign scanAddr   = ADDR_SZ'(pixAddr(32'(x), 32'(y), 32'(WIDTH)));
    assign ram_addr   = (state == ST_WAIT_FIND) ? find_addr : scanAddr;
    assign bright     = pix_q > COL_SZ'(THRESHOLD);
    assign lastColumn = (x == X_SZ'(WIDTH - 1));
    assign lastPixel  = lastColumn && (y == Y_SZ'(HEIGHT - 1));
    assign tableClear = start && (state == ST_IDLE || state == ST_DONE);
    assign tableWrite = (state == ST_WAIT_FIND) && find_done;

    // Status and handshake outputs decode directly from the state register
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign frame_done = (state == ST_DONE);
    assign star_valid = (state == ST_EMIT);
    assign find_start = (state == ST_LAUNCH);

    star_box_table #(
        .X_SZ      (X_SZ),
        .Y_SZ      (Y_SZ),
        .MAX_STARS (MAX_STARS),
        .IDX_SZ    (IDX_SZ)
    ) boxTable (
        .clk      (clk),
        .reset    (reset),
        .clear    (tableClear),
        .wrEn     (tableWrite),
        .wrIdx    (IDX_SZ'(star_count)),
        .wrTop    (find_top),
        .wrBottom (find_bottom),
        .wrLeft   (find_left),
        .wrRight  (find_right),
        .qX       (x),
        .qY       (y),
        .covered  (covered)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            x           <= '0;
            y           <= '0;
            star_count  <= '0;
            overflow    <= 1'b0;
            find_x      <= '0;
            find_y      <= '0;
            star_top    <= '0;
            star_bottom <= '0;
            star_left   <= '0;
            star_right  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x          <= '0;
                        y          <= '0;
                        star_count <= '0;
                        overflow   <= 1'b0;
                        state      <= ST_SCAN_ADDR;
                    end
                end
                ST_SCAN_ADDR: state <= ST_SCAN_CHK;
                ST_SCAN_CHK: begin
                    if (bright && !covered) begin
                        find_x <= x;
                        find_y <= y;
                        state  <= ST_LAUNCH;
                    end else if (lastPixel) begin
                        state <= ST_DONE;
                    end else begin
                        x     <= lastColumn ? '0 : x + 1'b1;
                        y     <= lastColumn ? y + 1'b1 : y;
                        state <= ST_SCAN_ADDR;
                    end
                end
                ST_LAUNCH: state <= ST_WAIT_FIND;
                ST_WAIT_FIND: begin
                    if (find_done) begin
                        star_top    <= find_top;
                        star_bottom <= find_bottom;
                        star_left   <= find_left;
                        star_right  <= find_right;
                        star_count  <= star_count + 1'b1;
                        state       <= ST_EMIT;
                    end
                end
                // A full table ends the frame early since further stars cannot be excluded
                ST_EMIT: begin
                    if (star_ready) begin
                        if (star_count == 3'(MAX_STARS)) begin
                            overflow <= 1'b1;
                            state    <= ST_DONE;
                        end else if (lastPixel) begin
                            state <= ST_DONE;
                        end else begin
                            x     <= lastColumn ? '0 : x + 1'b1;
                            y     <= lastColumn ? y + 1'b1 : y;
                            state <= ST_SCAN_ADDR;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_star_scan_sequencer.sv
// Directed bench for star_scan_sequencer with a pixel RAM model and a simple extent finder model.
module tb_star_scan_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [5:0] ram_addr;
    logic [2:0] pix_q;
    logic       find_start;
    logic [2:0] find_x, find_y;
    logic [5:0] find_addr;
    logic       find_done;
    logic [2:0] find_top, find_bottom, find_left, find_right;
    logic       star_valid;
    logic       star_ready;
    logic [2:0] star_top, star_bottom, star_left, star_right;
    logic [2:0] star_count;
    logic       busy, frame_done, overflow;

    logic [2:0] mem [0:63];

    int checks = 0;
    int errors = 0;

    int busyCycles = 0;
    int launchCount = 0;
    int recCount = 0;
    logic [2:0] launchX = 0, launchY = 0;
    logic [2:0] rec0Top = 0, rec0Left = 0;

    logic       finderHold = 1'b0;
    logic       fixedBox = 1'b0;
    logic [2:0] fixTop = 0, fixBottom = 0, fixLeft = 0, fixRight = 0;

    star_scan_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ram_addr    (ram_addr),
        .pix_q       (pix_q),
        .find_start  (find_start),
        .find_x      (find_x),
        .find_y      (find_y),
        .find_addr   (find_addr),
        .find_done   (find_done),
        .find_top    (find_top),
        .find_bottom (find_bottom),
        .find_left   (find_left),
        .find_right  (find_right),
        .star_valid  (star_valid),
        .star_ready  (star_ready),
        .star_top    (star_top),
        .star_bottom (star_bottom),
        .star_left   (star_left),
        .star_right  (star_right),
        .star_count  (star_count),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Synchronous-read pixel RAM
    always @(posedge clk) pix_q <= mem[ram_addr];

    // Extent finder model: answers three cycles after launch, owning the RAM port meanwhile
    initial begin
        int timer;
        logic pending;
        logic [2:0] seedX, seedY;
        pending = 1'b0;
        timer = 0;
        seedX = 0;
        seedY = 0;
        find_done = 1'b0;
        find_addr = 6'd0;
        find_top = 0;
        find_bottom = 0;
        find_left = 0;
        find_right = 0;
        forever begin
            @(negedge clk);
            find_done = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else if (pending) begin
                timer--;
                if (timer <= 0 && !finderHold) begin
                    if (fixedBox) begin
                        find_top = fixTop;
                        find_bottom = fixBottom;
                        find_left = fixLeft;
                        find_right = fixRight;
                    end else begin
                        find_top = seedY;
                        find_bottom = seedY;
                        find_left = seedX;
                        find_right = seedX;
                    end
                    find_done = 1'b1;
                    pending = 1'b0;
                end
            end else if (find_start) begin
                pending = 1'b1;
                timer = 3;
                seedX = find_x;
                seedY = find_y;
                find_addr = 6'd33;
            end
        end
    end

    // Activity monitor sampled just after the falling edge
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (busy) busyCycles++;
            if (find_start) begin
                launchCount++;
                launchX = find_x;
                launchY = find_y;
            end
            if (star_valid && star_ready) begin
                if (recCount == 0) begin
                    rec0Top = star_top;
                    rec0Left = star_left;
                end
                recCount++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clearFrame();
        for (int i = 0; i < 64; i++) mem[i] = 3'd0;
    endtask

    task automatic setPixel(input int px, input int py, input logic [2:0] v);
        mem[py * 6 + px] = v;
    endtask

    task automatic resetCounters();
        busyCycles = 0;
        launchCount = 0;
        recCount = 0;
    endtask

    // Pulse start, then wait (bounded) for the frame to finish
    task automatic applyStimulus(input string tag);
        int n;
        resetCounters();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busyAfterStart"}, busy, 1);
        checkOutput({tag, "_doneCleared"}, frame_done, 0);
        n = 0;
        while (!frame_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_frameDone"}, frame_done, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        star_ready = 1'b1;
        clearFrame();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_frameDone", frame_done, 0);
        checkOutput("rst_valid", star_valid, 0);
        checkOutput("rst_findStart", find_start, 0);
        checkOutput("rst_count", star_count, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_ramAddr", ram_addr, 0);

        $display("[TB] blank frame");
        applyStimulus("blank");
        checkOutput("blank_busyCycles", busyCycles, 72);
        checkOutput("blank_launches", launchCount, 0);
        checkOutput("blank_count", star_count, 0);
        checkOutput("blank_overflow", overflow, 0);

        $display("[TB] single pixel at (2,1)");
        setPixel(2, 1, 3'd5);
        applyStimulus("single");
        checkOutput("single_launches", launchCount, 1);
        checkOutput("single_findX", launchX, 2);
        checkOutput("single_findY", launchY, 1);
        checkOutput("single_records", recCount, 1);
        checkOutput("single_top", star_top, 1);
        checkOutput("single_bottom", star_bottom, 1);
        checkOutput("single_left", star_left, 2);
        checkOutput("single_right", star_right, 2);
        checkOutput("single_count", star_count, 1);
        checkOutput("single_busyCycles", busyCycles, 77);
        repeat (5) @(negedge clk);
        checkOutput("single_doneHeld", frame_done, 1);
        checkOutput("single_countHeld", star_count, 1);

        $display("[TB] 2x2 star");
        clearFrame();
        setPixel(3, 2, 3'd7);
        setPixel(4, 2, 3'd7);
        setPixel(3, 3, 3'd7);
        setPixel(4, 3, 3'd7);
        fixedBox = 1'b1;
        fixTop = 3'd2;
        fixBottom = 3'd3;
        fixLeft = 3'd3;
        fixRight = 3'd4;
        applyStimulus("square");
        checkOutput("square_launches", launchCount, 1);
        checkOutput("square_findX", launchX, 3);
        checkOutput("square_findY", launchY, 2);
        checkOutput("square_records", recCount, 1);
        checkOutput("square_bottom", star_bottom, 3);
        checkOutput("square_right", star_right, 4);
        checkOutput("square_busyCycles", busyCycles, 77);
        fixedBox = 1'b0;

        $display("[TB] five pixels, table overflow");
        clearFrame();
        setPixel(0, 0, 3'd1);
        setPixel(2, 0, 3'd1);
        setPixel(4, 0, 3'd1);
        setPixel(1, 2, 3'd1);
        setPixel(3, 4, 3'd1);
        applyStimulus("over");
        checkOutput("over_records", recCount, 4);
        checkOutput("over_launches", launchCount, 4);
        checkOutput("over_overflow", overflow, 1);
        checkOutput("over_count", star_count, 4);
        checkOutput("over_rec0Top", rec0Top, 0);
        checkOutput("over_rec0Left", rec0Left, 0);
        checkOutput("over_lastTop", star_top, 2);
        checkOutput("over_lastLeft", star_left, 1);
        checkOutput("over_busyCycles", busyCycles, 48);

        $display("[TB] back-pressure");
        clearFrame();
        setPixel(2, 1, 3'd4);
        star_ready = 1'b0;
        resetCounters();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!star_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_validSeen", star_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_validHeld", star_valid, 1);
            checkOutput("bp_topHeld", star_top, 1);
            checkOutput("bp_leftHeld", star_left, 2);
            checkOutput("bp_ramAddr", ram_addr, 8);
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            if (i == 9) star_ready = 1'b1;
        end
        n = 0;
        while (!frame_done && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_frameDone", frame_done, 1);
        checkOutput("bp_records", recCount, 1);
        checkOutput("bp_count", star_count, 1);
        checkOutput("bp_busyCycles", busyCycles, 87);

        $display("[TB] reset during WAIT_FIND");
        finderHold = 1'b1;
        resetCounters();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (launchCount == 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rw_launched", launchCount, 1);
        checkOutput("rw_grant", ram_addr, 33);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rw_busy", busy, 0);
        checkOutput("rw_valid", star_valid, 0);
        checkOutput("rw_count", star_count, 0);
        checkOutput("rw_findStart", find_start, 0);
        checkOutput("rw_frameDone", frame_done, 0);
        reset = 1'b0;
        finderHold = 1'b0;
        applyStimulus("rescan");
        checkOutput("rescan_launches", launchCount, 1);
        checkOutput("rescan_findX", launchX, 2);
        checkOutput("rescan_findY", launchY, 1);
        checkOutput("rescan_count", star_count, 1);
        checkOutput("rescan_busyCycles", busyCycles, 77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/star_scan_sequencer.md
Name: star_scan_sequencer

Overview:
- Frame-level controller for the star-finding pipeline.
- Raster-scans the read-only pixel RAM and detects bright pixels not already covered by a recorded star.
- Launches the extent finder (top/bottom/left/right search engine) and owns the single RAM read port, multiplexing it between the scanner and the finder.
- Emits one bounding-box record per star over a valid/ready interface.

Parameters:
- X_SZ, 3, x coordinate width
- Y_SZ, 3, y coordinate width
- ADDR_SZ, 6, RAM address width
- COL_SZ, 3, pixel value width
- WIDTH, 6, image width in pixels
- HEIGHT, 6, image height in pixels
- THRESHOLD, 0, a pixel is bright when pix_q > THRESHOLD
- MAX_STARS, 4, capacity of the exclusion box table

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begin a frame scan (ignored unless IDLE or DONE)
- ram_addr  out  ADDR_SZ  RAM read address
- pix_q  in  COL_SZ  RAM data; valid the cycle after ram_addr
- find_start  out  1  one-cycle launch pulse to the extent finder
- find_x  out  X_SZ  seed x, held stable while finder is busy
- find_y  out  Y_SZ  seed y, held stable while finder is busy
- find_addr  in  ADDR_SZ  finder's requested address, forwarded while granted
- find_done  in  1  one-cycle pulse; extent results valid
- find_top, find_bottom  in  Y_SZ  extents from finder
- find_left, find_right  in  X_SZ  extents from finder
- star_valid  out  1  record available
- star_ready  in  1  consumer accepts the record
- star_top, star_bottom  out  Y_SZ  record fields
- star_left, star_right  out  X_SZ  record fields
- star_count  out  3  stars recorded this frame
- busy  out  1  high in every state except IDLE and DONE
- frame_done  out  1  high in DONE
- overflow  out  1  table filled before the scan completed

Behaviour:
- Reset values:
  - state IDLE, all outputs 0, ram_addr 0.
  - Table entries invalidated; x, y counters 0.
  - Reset mid-operation abandons the frame immediately; find_start is not issued.
- Address rule: addr = y*WIDTH + x, computed with unsigned zero-extended operands.
- Grant: ram_addr = find_addr in WAIT_FIND, otherwise the scan address.
- IDLE / DONE: on start, clear x, y, star_count, overflow and the table, then go to SCAN_ADDR.
- SCAN_ADDR: drive the scan address for (x, y); next state SCAN_CHK. Scan rate is 2 cycles per pixel.
- SCAN_CHK: evaluate pix_q.
  - If bright and (x, y) lies inside no valid table box (inclusive left..right, top..bottom), go to LAUNCH.
  - Otherwise advance the counters and return to SCAN_ADDR.
- Counter advance: x+1; on x = WIDTH-1, x wraps to 0 and y increments.
- End of frame: advancing from (WIDTH-1, HEIGHT-1) goes to DONE.
- LAUNCH: find_start = 1 for exactly one cycle, find_x = x, find_y = y; next state WAIT_FIND.
- WAIT_FIND: wait with no timeout. On find_done:
  - latch the four extents into the output record and into table[star_count];
  - increment star_count;
  - go to EMIT.
- EMIT: hold star_valid = 1 with stable fields until star_valid && star_ready.
  - On the accepting cycle: if star_count == MAX_STARS, set overflow and go to DONE. If the current pixel is the last, go to DONE. Otherwise advance the counters and go to SCAN_ADDR.
  - star_ready while star_valid = 0 is ignored.
- Simultaneous events:
  - start while busy is ignored.
  - find_done outside WAIT_FIND is ignored.
  - A start arriving in DONE clears frame_done the next cycle.
- DONE: frame_done = 1; all table contents and star_count hold until the next start.

Decomposition:
- Shared package:
  - state encoding localparams;
  - THRESHOLD default;
  - box record field widths;
  - the address formula as a function, so it can be shared with the finder.
- One sub-module: star_box_table. It holds MAX_STARS valid+box entries with a write port and a combinational "point covered" query.
- The FSM, counters and RAM mux stay in the top module.

Test Plan:
- Blank frame (all pixels 0), start pulse -> 36 pixels scanned; frame_done after 72 scan cycles; star_count = 0; find_start never asserted.
- Single bright pixel at (2,1), finder model returns box 1..1 / 2..2 -> find_start once with find_x = 2, find_y = 1; one record top = 1, bottom = 1, left = 2, right = 2; star_count = 1.
- 2x2 star at x 3..4, y 2..3 -> exactly one launch, at (3,2); pixels (4,2), (3,3), (4,3) are suppressed by the table.
- Five separated single pixels with MAX_STARS = 4 -> four records; overflow = 1; frame_done without scanning the remainder.
- Back-pressure: hold star_ready = 0 for 10 cycles in EMIT -> fields stable and scan paused; ram_addr is unchanged during EMIT.
- Reset asserted during WAIT_FIND -> the next cycle shows IDLE, busy = 0, star_valid = 0, star_count = 0; a following start rescans from (0,0).
